// File: rtl/if_id_elastic.sv
`default_nettype none
// ============================================================================
// Module      : if_id_elastic
// Description : Fetch-to-decode elastic buffer. Holds up to DEPTH pc/inst
//               pairs behind a valid/ready handshake. Includes a flush that
//               overrides every other input and a saturating count of the
//               valid entries that flushes have discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_elastic #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 2,   // 1 (half-rate area option) or 2 (full rate)
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [1:0]        count_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam logic [1:0] c_depth = 2'(DEPTH);
  // Pointers toggle only when there are two slots; with one slot they stay 0.
  localparam logic       c_wrap  = (DEPTH == 2);

  logic [PC_W-1:0]   r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic              r_rptr;
  logic              r_wptr;
  logic [1:0]        r_count;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic              w_push;
  logic              w_pop;
  logic [CNT_W:0]    w_flush_sum;
  logic [CNT_W-1:0]  w_flush_next;

  // Ready and valid come from registered occupancy only, so out_ready never
  // reaches in_ready combinationally and in_* never reaches out_*.
  assign in_ready  = (r_count < c_depth);
  assign out_valid = (r_count != 2'd0);
  assign out_pc    = out_valid ? r_pc_mem[r_rptr]   : '0;
  assign out_inst  = out_valid ? r_inst_mem[r_rptr] : '0;
  assign count_o     = r_count;
  assign flush_cnt_o = r_flush_cnt;

  // Flush suppresses both handshakes; the pair offered with it is dropped.
  assign w_push = in_valid  & in_ready  & ~flush_i;
  assign w_pop  = out_valid & out_ready & ~flush_i;

  // One extra bit catches the carry so the statistic saturates, never wraps.
  assign w_flush_sum  = {1'b0, r_flush_cnt} + (CNT_W+1)'(r_count);
  assign w_flush_next = w_flush_sum[CNT_W] ? {CNT_W{1'b1}} : w_flush_sum[CNT_W-1:0];

  // Occupancy, pointers and flush statistic; flush has highest priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count     <= 2'd0;
      r_rptr      <= 1'b0;
      r_wptr      <= 1'b0;
      r_flush_cnt <= '0;
    end else if (flush_i) begin
      r_count     <= 2'd0;
      r_rptr      <= 1'b0;
      r_wptr      <= 1'b0;
      r_flush_cnt <= w_flush_next;
    end else begin
      if (w_push) r_wptr <= c_wrap & ~r_wptr;
      if (w_pop)  r_rptr <= c_wrap & ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage: written at the tail on every accepted push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_inst_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_pc_mem[r_wptr]   <= in_pc;
      r_inst_mem[r_wptr] <= in_inst;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_elastic.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_elastic
// Description : Directed bench for if_id_elastic. One instance with two
//               slots and a 2-bit flush counter, one with a single slot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_elastic;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Two-slot instance
  logic        flush2, iv2, ir2, ov2, ordy2;
  logic [31:0] ipc2, iinst2, opc2, oinst2;
  logic [1:0]  cnt2;
  logic [1:0]  fc2;

  // One-slot instance
  logic        flush1, iv1, ir1, ov1, ordy1;
  logic [31:0] ipc1, iinst1, opc1, oinst1;
  logic [1:0]  cnt1;
  logic [15:0] fc1;

  int checks = 0;
  int errors = 0;

  if_id_elastic #(.PC_W(32), .INST_W(32), .DEPTH(2), .CNT_W(2)) u_d2 (
    .clk(clk), .rst(rst), .flush_i(flush2),
    .in_valid(iv2), .in_ready(ir2), .in_pc(ipc2), .in_inst(iinst2),
    .out_valid(ov2), .out_ready(ordy2), .out_pc(opc2), .out_inst(oinst2),
    .count_o(cnt2), .flush_cnt_o(fc2)
  );

  if_id_elastic #(.PC_W(32), .INST_W(32), .DEPTH(1), .CNT_W(16)) u_d1 (
    .clk(clk), .rst(rst), .flush_i(flush1),
    .in_valid(iv1), .in_ready(ir1), .in_pc(ipc1), .in_inst(iinst1),
    .out_valid(ov1), .out_ready(ordy1), .out_pc(opc1), .out_inst(oinst1),
    .count_o(cnt1), .flush_cnt_o(fc1)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer2(input logic v, input logic [31:0] pc);
    iv2    = v;
    ipc2   = pc;
    iinst2 = inst_of(pc);
  endtask

  initial begin
    flush2 = 0; iv2 = 0; ordy2 = 0; ipc2 = 0; iinst2 = 0;
    flush1 = 0; iv1 = 0; ordy1 = 0; ipc1 = 0; iinst1 = 0;

    // ---------------- reset state ----------------
    #3;
    chk("rst_count", cnt2, 2'd0);
    chk("rst_valid", ov2, 1'b0);
    chk("rst_pc", opc2, 32'h0);
    chk("rst_inst", oinst2, 32'h0);
    chk("rst_fcnt", fc2, 2'd0);
    chk("rst_ready", ir2, 1'b1);
    #9 rst = 1'b1;          // release between edges
    tick();

    // ---------------- streaming ----------------
    ordy2 = 1;
    offer2(1, 32'h00);
    tick();
    chk("str0_pc", opc2, 32'h00);
    chk("str0_inst", oinst2, inst_of(32'h00));
    chk("str0_cnt", cnt2, 2'd1);
    chk("str0_rdy", ir2, 1'b1);
    offer2(1, 32'h04);
    tick();
    chk("str1_pc", opc2, 32'h04);
    chk("str1_cnt", cnt2, 2'd1);
    chk("str1_rdy", ir2, 1'b1);
    offer2(1, 32'h08);
    tick();
    chk("str2_pc", opc2, 32'h08);
    chk("str2_cnt", cnt2, 2'd1);
    chk("str2_rdy", ir2, 1'b1);
    offer2(0, 32'h0);
    tick();
    chk("str_drain_cnt", cnt2, 2'd0);
    chk("str_drain_valid", ov2, 1'b0);
    chk("str_drain_pc", opc2, 32'h0);

    // underflow guard: out_ready while empty
    tick();
    chk("empty_pop_cnt", cnt2, 2'd0);

    // ---------------- back-pressure ----------------
    ordy2 = 0;
    offer2(1, 32'h10);
    tick();
    chk("bp_cnt1", cnt2, 2'd1);
    offer2(1, 32'h14);
    tick();
    chk("bp_cnt2", cnt2, 2'd2);
    chk("bp_full_rdy", ir2, 1'b0);
    offer2(1, 32'h18);        // held by fetch while full
    tick();
    chk("bp_hold_cnt", cnt2, 2'd2);
    chk("bp_hold_pc", opc2, 32'h10);
    chk("bp_hold_rdy", ir2, 1'b0);
    ordy2 = 1;
    tick();                   // pop 0x10, no push (was full)
    chk("bp_out10_next", opc2, 32'h14);
    chk("bp_cnt_a", cnt2, 2'd1);
    tick();                   // pop 0x14, push 0x18
    chk("bp_out18", opc2, 32'h18);
    chk("bp_inst18", oinst2, inst_of(32'h18));
    chk("bp_cnt_b", cnt2, 2'd1);
    offer2(0, 32'h0);
    tick();
    chk("bp_drain_cnt", cnt2, 2'd0);

    // ---------------- flush priority ----------------
    ordy2 = 0;
    offer2(1, 32'h40);
    tick();
    offer2(1, 32'h44);
    tick();
    chk("fl_pre_cnt", cnt2, 2'd2);
    flush2 = 1;
    offer2(1, 32'h20);
    tick();
    chk("fl_cnt", cnt2, 2'd0);
    chk("fl_valid", ov2, 1'b0);
    chk("fl_inst", oinst2, 32'h0);
    chk("fl_fcnt", fc2, 2'd2);
    flush2 = 0;
    offer2(0, 32'h0);
    tick();
    chk("fl_no20_valid", ov2, 1'b0);
    chk("fl_no20_pc", opc2, 32'h0);

    // flush while empty leaves the statistic alone
    flush2 = 1;
    tick();
    flush2 = 0;
    chk("fl_empty_fcnt", fc2, 2'd2);

    // ---------------- saturation ----------------
    offer2(1, 32'h50);
    tick();
    offer2(1, 32'h54);
    tick();
    flush2 = 1;
    offer2(0, 32'h0);
    tick();
    flush2 = 0;
    chk("sat_fcnt3", fc2, 2'd3);
    offer2(1, 32'h58);
    tick();
    offer2(1, 32'h5C);
    tick();
    chk("sat_pre_cnt", cnt2, 2'd2);
    flush2 = 1;
    offer2(0, 32'h0);
    tick();
    flush2 = 0;
    chk("sat_fcnt_hold", fc2, 2'd3);

    // ---------------- reset mid-stream ----------------
    offer2(1, 32'h60);
    tick();
    offer2(1, 32'h64);
    tick();
    offer2(0, 32'h0);
    chk("mr_pre_cnt", cnt2, 2'd2);
    #2 rst = 1'b0;            // between edges
    #1;
    chk("mr_cnt", cnt2, 2'd0);
    chk("mr_valid", ov2, 1'b0);
    chk("mr_pc", opc2, 32'h0);
    chk("mr_inst", oinst2, 32'h0);
    chk("mr_fcnt", fc2, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("mr_after_cnt", cnt2, 2'd0);

    // ---------------- single slot, half rate ----------------
    ordy1 = 1;
    iv1   = 1;
    chk("d1_rdy_init", ir1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      ipc1   = 32'h100 + 32'(4 * ((i + 1) / 2));
      iinst1 = inst_of(ipc1);
      tick();
      chk("d1_rdy", ir1, (i % 2) == 1);
      chk("d1_valid", ov1, (i % 2) == 0);
      chk("d1_pc", opc1, ((i % 2) == 0) ? 32'h100 + 32'(4 * (i / 2)) : 32'h0);
    end
    iv1 = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_id_elastic.md
Name: if_id_elastic

Overview:
- Parametrised successor to the fixed IF/ID pipeline register.
- Sits between fetch and decode.
- Replaces the single register and halt_type stalling with a valid/ready elastic buffer of DEPTH entries, so decode back-pressure does not drop or duplicate fetched instructions.
- Adds a same-cycle flush with priority over all other inputs, plus a saturating flush statistic.

Parameters:
- PC_W, 32, width of the instruction address.
- INST_W, 32, width of the instruction word.
- DEPTH, 2, number of buffered entries; legal values are 1 and 2.
- CNT_W, 16, width of the saturating flush counter.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- flush_i  input  1  branch/jump discard; empties the buffer.
- in_valid  input  1  fetch presents a pc/inst pair.
- in_ready  output  1  buffer can accept the pair this cycle.
- in_pc  input  PC_W  fetched PC.
- in_inst  input  INST_W  fetched instruction.
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  PC_W  head PC; zero when out_valid=0.
- out_inst  output  INST_W  head instruction; zero (bubble) when out_valid=0.
- count_o  output  2  number of occupied entries (0..DEPTH).
- flush_cnt_o  output  CNT_W  number of valid entries discarded by flushes, saturating.

Behaviour:
- Reset (rst=0, asynchronous): count=0, out_valid=0, out_pc=0, out_inst=0, flush_cnt_o=0, storage cleared, read/write pointers=0. Reset may assert mid-operation; all in-flight entries are lost.
- Storage: circular buffer of DEPTH entries with 1-bit read/write pointers.
  - DEPTH=1: pointers stay 0.
  - DEPTH=2: pointers toggle on each pop/push respectively.
- Handshake definitions:
  - push = in_valid & in_ready & !flush_i.
  - pop = out_valid & out_ready & !flush_i.
- in_ready = (count < DEPTH). It depends only on registered state, so there is no combinational path from out_ready to in_ready.
- out_valid = (count != 0). out_pc and out_inst equal the head entry when out_valid=1, else zero.
- Latency: a pair pushed in cycle N is visible on the outputs in cycle N+1 if the buffer was empty. Throughput is one entry per cycle when DEPTH=2 and decode is always ready.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged; the head advances and the new entry is written at the tail.
  - DEPTH=1, full: in_ready=0, so a same-cycle push and pop cannot occur. The stage therefore sustains only half rate, which is documented as the area option.
- Flush (flush_i=1) has priority over push and pop:
  - Next cycle: count=0, pointers reset to 0, out_valid=0, outputs zero.
  - The in_pc/in_inst offered in the flush cycle are discarded even if in_valid=1.
  - flush_cnt_o += count (current occupancy), saturating at 2^CNT_W-1. It never wraps.
  - Flush with count=0 leaves flush_cnt_o unchanged.
- Stall: out_ready=0 with count=DEPTH holds all entries and outputs stable, and in_ready=0.
- Full/empty boundaries:
  - in_valid while full is ignored; fetch must hold the pair.
  - out_ready while empty is ignored; count never underflows.
- Inputs are sampled only on the rising clk edge. There is no combinational path from in_* to out_*.

Test Plan:
- Reset mid-stream: fill 2 entries, then assert rst=0 asynchronously between edges. Required: outputs go to zero immediately; count_o=0 and flush_cnt_o=0 before the next edge.
- Streaming: DEPTH=2, out_ready=1, push pc 0x00, 0x04, 0x08 on consecutive cycles. Required: out_pc 0x00, 0x04, 0x08 on the following consecutive cycles, in_ready constantly 1, count_o constantly 1.
- Back-pressure: out_ready=0 and push 0x10, 0x14. Required: count_o=2, in_ready=0, and 0x18 held by fetch is not accepted. Raise out_ready. Required: outputs 0x10, 0x14, 0x18 in order, with no loss or duplication.
- Flush priority: count=2, then flush_i=1 with in_valid=1, in_pc=0x20 in the same cycle. Required: next cycle count_o=0, out_valid=0, out_inst=0, flush_cnt_o=2, and 0x20 is never emitted.
- Saturation: CNT_W=2; issue three flushes while count=2. Required: flush_cnt_o reads 2, then 3, then 3.
- DEPTH=1: continuous pushes with out_ready=1. Required: in_ready alternates 1,0,1,0 and one instruction emerges every two cycles.
